// File: rtl/fifo_pixel_reader_pkg.sv
// Shared definitions for the FIFO pixel reader: default geometry and FSM encoding.
package fifo_pixel_reader_pkg;

    localparam int unsigned DefB    = 8;
    localparam int unsigned DefCols = 640;
    localparam int unsigned DefRows = 480;

    typedef enum logic [1:0] {
        StIdle   = 2'd0,
        StStream = 2'd1,
        StDrain  = 2'd2
    } state_e;

endpackage

// File: rtl/raster_counter.sv
// Column/row position counter for one frame, with start/end-of-line/frame decode.
module raster_counter
    import fifo_pixel_reader_pkg::*;
#(
    parameter int unsigned COLS = DefCols,
    parameter int unsigned ROWS = DefRows,
    parameter int unsigned CW   = ($clog2(COLS) > 0) ? $clog2(COLS) : 1,
    parameter int unsigned RW   = ($clog2(ROWS) > 0) ? $clog2(ROWS) : 1
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          clear,
    input  logic          inc,
    output logic [CW-1:0] col,
    output logic [RW-1:0] row,
    output logic          sof,
    output logic          eol,
    output logic          eof
);

    localparam logic [CW-1:0] ColLast = CW'(COLS - 1);
    localparam logic [RW-1:0] RowLast = RW'(ROWS - 1);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            col <= '0;
            row <= '0;
        end else if (clear) begin
            col <= '0;
            row <= '0;
        end else if (inc) begin
            if (col == ColLast) begin
                col <= '0;
                row <= (row == RowLast) ? '0 : row + 1'b1;
            end else begin
                col <= col + 1'b1;
            end
        end
    end

    assign sof = (col == '0) && (row == '0);
    assign eol = (col == ColLast);
    assign eof = eol && (row == RowLast);

endmodule

// File: rtl/fifo_pixel_reader.sv
// Pops one frame of pixels from a FWFT FIFO and presents them on a valid/ready
// stream with sof/eol/eof markers; returns to idle once the eof pixel is taken.
module fifo_pixel_reader
    import fifo_pixel_reader_pkg::*;
#(
    parameter int unsigned B    = DefB,
    parameter int unsigned COLS = DefCols,
    parameter int unsigned ROWS = DefRows
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         start,
    input  logic         empty,
    input  logic [B-1:0] rdata,
    output logic         rd,
    output logic         m_valid,
    input  logic         m_ready,
    output logic [B-1:0] m_data,
    output logic         m_sof,
    output logic         m_eol,
    output logic         m_eof,
    output logic         busy,
    output logic         done
);

    localparam int unsigned CW = ($clog2(COLS) > 0) ? $clog2(COLS) : 1;
    localparam int unsigned RW = ($clog2(ROWS) > 0) ? $clog2(ROWS) : 1;

    state_e        state;
    logic          accept;
    logic          start_frame;
    logic [CW-1:0] col;
    logic [RW-1:0] row;
    logic          c_sof;
    logic          c_eol;
    logic          c_eof;

    assign start_frame = start & (state == StIdle);
    assign accept      = m_valid & m_ready;
    // Gated by reset so the pop strobe drops in the same instant reset rises.
    assign rd          = ~reset & (state == StStream) & ~empty & (~m_valid | m_ready);
    assign busy        = (state != StIdle);
    assign done        = (state == StDrain) & accept;

    raster_counter #(
        .COLS (COLS),
        .ROWS (ROWS),
        .CW   (CW),
        .RW   (RW)
    ) u_raster_counter (
        .clk   (clk),
        .reset (reset),
        .clear (start_frame),
        .inc   (rd),
        .col   (col),
        .row   (row),
        .sof   (c_sof),
        .eol   (c_eol),
        .eof   (c_eof)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state   <= StIdle;
            m_valid <= 1'b0;
            m_data  <= '0;
            m_sof   <= 1'b0;
            m_eol   <= 1'b0;
            m_eof   <= 1'b0;
        end else begin
            if (rd) begin
                m_valid <= 1'b1;
                m_data  <= rdata;
                m_sof   <= c_sof;
                m_eol   <= c_eol;
                m_eof   <= c_eof;
            end else if (accept) begin
                m_valid <= 1'b0;
            end

            unique case (state)
                StIdle: begin
                    if (start) state <= StStream;
                end
                StStream: begin
                    if (rd && c_eof) state <= StDrain;
                end
                StDrain: begin
                    // Only the eof pixel can be pending here.
                    if (accept) state <= StIdle;
                end
                default: state <= StIdle;
            endcase
        end
    end

endmodule

// File: tb/tb_fifo_pixel_reader.sv
// Scoreboard bench for fifo_pixel_reader with a 4x2 frame and a queue-modelled FWFT FIFO.
module tb_fifo_pixel_reader;

    typedef struct packed {
        logic [7:0] d;
        logic       sof;
        logic       eol;
        logic       eof;
    } pix_t;

    logic       clk;
    logic       reset;
    logic       start;
    logic       empty;
    logic [7:0] rdata;
    logic       rd;
    logic       m_valid;
    logic       m_ready;
    logic [7:0] m_data;
    logic       m_sof;
    logic       m_eol;
    logic       m_eof;
    logic       busy;
    logic       done;

    logic [7:0] fifo_q[$];
    pix_t       exp_q[$];
    bit         hold_empty;

    int n_vec;
    int n_err;
    int n_pop;
    int n_acc;
    int n_done;
    int first_rd;
    int last_rd;
    int first_acc;
    int last_acc;

    fifo_pixel_reader #(
        .B    (8),
        .COLS (4),
        .ROWS (2)
    ) dut (
        .clk     (clk),
        .reset   (reset),
        .start   (start),
        .empty   (empty),
        .rdata   (rdata),
        .rd      (rd),
        .m_valid (m_valid),
        .m_ready (m_ready),
        .m_data  (m_data),
        .m_sof   (m_sof),
        .m_eol   (m_eol),
        .m_eof   (m_eof),
        .busy    (busy),
        .done    (done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic drive_fifo();
        empty = hold_empty || (fifo_q.size() == 0);
        rdata = (fifo_q.size() != 0) ? fifo_q[0] : 8'h00;
    endtask

    task automatic load_frame(input logic [7:0] base);
        pix_t p;
        for (int i = 0; i < 8; i++) begin
            fifo_q.push_back(base + 8'(i));
            p.d   = base + 8'(i);
            p.sof = (i == 0);
            p.eol = (i % 4 == 3);
            p.eof = (i == 7);
            exp_q.push_back(p);
        end
    endtask

    // Runs one frame from a start pulse. bp_trig: hold m_ready low 3 cycles while that
    // word is shown; uf_trig: force empty 5 cycles after that word pops; abort_pops: return
    // after that many pops; start_noise: extra start pulses in STREAM and in the done cycle.
    task automatic run_frame(input int bp_trig, input int uf_trig, input int abort_pops,
                             input bit start_noise);
        bit   bp_fired;
        bit   uf_pend;
        bit   fin;
        bit   exp_done;
        int   bp_left;
        int   uf_left;
        int   uf_idx;
        pix_t item;
        logic [7:0] pv;
        bp_fired = 0; uf_pend = 0; fin = 0;
        bp_left = 0; uf_left = 0; uf_idx = 0;
        n_pop = 0; n_acc = 0; n_done = 0;
        first_rd = -1; last_rd = -1; first_acc = -1; last_acc = -1;
        for (int cyc = 0; cyc < 60 && !fin; cyc++) begin
            start = (cyc == 0) || (start_noise && cyc == 3);
            if (!bp_fired && bp_trig >= 0 && m_valid && m_data == 8'(bp_trig)) begin
                bp_fired = 1;
                bp_left  = 3;
            end
            if (uf_pend) begin
                uf_pend = 0;
                uf_left = 5;
                uf_idx  = 0;
            end
            m_ready    = (bp_left == 0);
            hold_empty = (uf_left > 0);
            if (start_noise && busy && m_valid && m_eof && m_ready) start = 1'b1;
            drive_fifo();
            #1;
            if (bp_left > 0) begin
                check_eq("bp_hold_data", 32'(m_data), 32'(bp_trig));
                check_eq("bp_rd_low", 32'(rd), 0);
                bp_left--;
            end
            if (uf_left > 0) begin
                check_eq("uf_rd_low", 32'(rd), 0);
                if (uf_idx >= 1) check_eq("uf_valid_clear", 32'(m_valid), 0);
                uf_idx++;
                uf_left--;
            end
            exp_done = 0;
            if (m_valid && m_ready) begin
                if (exp_q.size() == 0) begin
                    check_eq("sb_extra_pixel", 1, 0);
                end else begin
                    item = exp_q.pop_front();
                    check_eq("pix_data", 32'(m_data), 32'(item.d));
                    check_eq("pix_sof", 32'(m_sof), 32'(item.sof));
                    check_eq("pix_eol", 32'(m_eol), 32'(item.eol));
                    check_eq("pix_eof", 32'(m_eof), 32'(item.eof));
                    exp_done = item.eof;
                end
                n_acc++;
                if (first_acc < 0) first_acc = cyc;
                last_acc = cyc;
            end
            check_eq("done", 32'(done), 32'(exp_done));
            if (done) n_done++;
            if (rd) begin
                if (fifo_q.size() == 0) begin
                    check_eq("pop_on_empty", 1, 0);
                end else begin
                    pv = fifo_q.pop_front();
                    if (uf_trig >= 0 && pv == 8'(uf_trig)) uf_pend = 1;
                end
                n_pop++;
                if (first_rd < 0) first_rd = cyc;
                last_rd = cyc;
            end
            @(posedge clk);
            @(negedge clk);
            if (exp_done || (abort_pops > 0 && n_pop == abort_pops)) fin = 1;
        end
        start = 1'b0;
        m_ready = 1'b1;
        hold_empty = 0;
        drive_fifo();
        if (!fin) check_eq("frame_timeout", 0, 1);
    endtask

    initial begin
        #200000;
        $display("FAIL global_timeout: got no finish, expected finish");
        $fatal(1);
    end

    initial begin
        n_vec = 0; n_err = 0;
        reset = 1'b1; start = 1'b0; m_ready = 1'b1; hold_empty = 0;
        drive_fifo();

        // Reset state, then start against an empty FIFO.
        repeat (2) @(posedge clk);
        @(negedge clk);
        #1;
        check_eq("rst_rd", 32'(rd), 0);
        check_eq("rst_valid", 32'(m_valid), 0);
        check_eq("rst_data", 32'(m_data), 0);
        check_eq("rst_flags", {29'd0, m_sof, m_eol, m_eof}, 0);
        check_eq("rst_busy", 32'(busy), 0);
        check_eq("rst_done", 32'(done), 0);
        @(negedge clk);
        reset = 1'b0;
        start = 1'b1;
        @(posedge clk);
        @(negedge clk);
        start = 1'b0;
        #1;
        check_eq("empty_start_busy", 32'(busy), 1);
        check_eq("empty_start_rd", 32'(rd), 0);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;

        // Full rate.
        load_frame(8'h10);
        run_frame(-1, -1, 0, 0);
        check_eq("fr_pops", n_pop, 8);
        check_eq("fr_rd_contig", last_rd - first_rd, 7);
        check_eq("fr_latency", first_acc - first_rd, 1);
        check_eq("fr_acc_contig", last_acc - first_acc, 7);
        check_eq("fr_done_cnt", n_done, 1);
        #1;
        check_eq("fr_idle_busy", 32'(busy), 0);
        check_eq("fr_idle_valid", 32'(m_valid), 0);

        // Backpressure on 0x12.
        load_frame(8'h10);
        run_frame(8'h12, -1, 0, 0);
        check_eq("bp_acc_cnt", n_acc, 8);
        check_eq("bp_sb_empty", exp_q.size(), 0);

        // Underflow after 0x14.
        load_frame(8'h10);
        run_frame(-1, 8'h14, 0, 0);
        check_eq("uf_acc_cnt", n_acc, 8);
        check_eq("uf_sb_empty", exp_q.size(), 0);

        // Reset mid-frame after 3 pops.
        load_frame(8'h20);
        run_frame(-1, -1, 3, 0);
        reset = 1'b1;
        #1;
        check_eq("mid_rst_rd", 32'(rd), 0);
        check_eq("mid_rst_valid", 32'(m_valid), 0);
        check_eq("mid_rst_busy", 32'(busy), 0);
        check_eq("mid_rst_sof", 32'(m_sof), 0);
        fifo_q.delete();
        exp_q.delete();
        @(negedge clk);
        reset = 1'b0;
        load_frame(8'h30);
        run_frame(-1, -1, 0, 0);
        check_eq("post_rst_acc_cnt", n_acc, 8);

        // Start noise in STREAM and in the done cycle.
        load_frame(8'h40);
        run_frame(-1, -1, 0, 1);
        check_eq("noise_done_cnt", n_done, 1);
        #1;
        check_eq("noise_idle_busy", 32'(busy), 0);
        @(negedge clk);
        start = 1'b1;
        #1;
        check_eq("noise_no_done", 32'(done), 0);
        @(posedge clk);
        @(negedge clk);
        start = 1'b0;
        #1;
        check_eq("restart_busy", 32'(busy), 1);
        check_eq("restart_rd", 32'(rd), 0);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/fifo_pixel_reader.md
FIFO_PIXEL_READER -- requirements
Module: fifo_pixel_reader

Interface
REQ-001 SHALL have parameter B, default 8: pixel/FIFO data width in bits.
REQ-002 SHALL have parameter COLS, default 640: pixels per line.
REQ-003 SHALL have parameter ROWS, default 480: lines per frame.
REQ-004 SHALL use one clock and an asynchronous, active-high reset.
REQ-005 clk  input  1  system clock; all state on rising edge.
REQ-006 reset  input  1  asynchronous, active-high reset.
REQ-007 start  input  1  one-cycle frame start request; honoured only in IDLE.
REQ-008 empty  input  1  FIFO empty flag.
REQ-009 rdata  input  B  FIFO head word; first-word-fall-through, valid whenever empty=0.
REQ-010 rd  output  1  FIFO pop strobe, combinational.
REQ-011 m_valid  output  1  output pixel valid.
REQ-012 m_ready  input  1  downstream accept.
REQ-013 m_data  output  B  output pixel.
REQ-014 m_sof / m_eol / m_eof  output  1 each  start of frame, end of line, end of frame; qualified by m_valid.
REQ-015 busy  output  1  high in any state other than IDLE.
REQ-016 done  output  1  one-cycle pulse when a frame completes.

Function
REQ-017 FSM states SHALL be IDLE, STREAM and DRAIN; start in IDLE moves to STREAM and clears the col and row counters.
REQ-018 pop condition SHALL be rd = (state==STREAM) & ~empty & (~m_valid | m_ready); rd SHALL never be high in IDLE or DRAIN.
REQ-019 on a pop edge, m_data SHALL load rdata, m_valid SHALL be set, and sof/eol/eof SHALL load from the current col/row.
REQ-020 latency: rd high in cycle N SHALL give m_valid with that word in cycle N+1.
REQ-021 throughput: with empty=0 and m_ready=1, one pixel per cycle with no bubbles, including a simultaneous accept and reload.
REQ-022 m_valid & ~m_ready SHALL hold m_data and all flags stable and keep rd low.
REQ-023 m_valid SHALL clear after an accept when no pop occurs in the same cycle.
REQ-024 col SHALL be $clog2(COLS) bits wide, row SHALL be $clog2(ROWS) bits wide, and both SHALL increment only on pop.
REQ-025 col SHALL wrap from COLS-1 to 0 and increment row.
REQ-026 sof SHALL be col==0 & row==0; eol SHALL be col==COLS-1; eof SHALL be eol & row==ROWS-1.
REQ-027 the pop of the eof pixel SHALL move the FSM to DRAIN.
REQ-028 DRAIN SHALL exit to IDLE on the accept of the eof pixel, with done high in that same cycle.
REQ-029 empty rising mid-frame SHALL stall pops with no loss or duplication; streaming SHALL resume at the saved col/row.
REQ-030 start SHALL be ignored outside IDLE.
REQ-031 start in the same cycle as the done pulse SHALL be ignored; start SHALL be accepted the following cycle.

Reset
REQ-032 reset SHALL force IDLE, col=0, row=0, m_valid=0, m_data=0, all flags=0, busy=0 and done=0.
REQ-033 reset asserted mid-frame SHALL drop rd combinationally and discard the frame; the next start SHALL begin at sof.

Structure
REQ-034 a shared package SHALL hold the state encoding constants and the default COLS/ROWS/B values.
REQ-035 one sub-module, raster_counter, SHALL implement the col/row counter with wrap, sof/eol/eof decode and increment enable.
REQ-036 the implementation SHALL be 120-400 lines of RTL in a single clock domain with no inferred latches.

Verification (B=8, COLS=4, ROWS=2)
REQ-037 Reset: assert reset for 2 cycles -> every output is 0 and rd is 0; then start with empty=1 -> busy=1, rd=0.
REQ-038 Full rate: FIFO preloaded with 0x10..0x17, m_ready=1, start -> rd high for 8 consecutive cycles; m_data 0x10..0x17 on consecutive cycles; sof on 0x10, eol on 0x13 and 0x17, eof on 0x17; done in the 0x17 accept cycle.
REQ-039 Backpressure: m_ready=0 for 3 cycles while holding 0x12 -> m_data stays 0x12, rd=0; resumes with 0x13 eol; all 8 words arrive in order.
REQ-040 Underflow: empty=1 for 5 cycles after pixel 0x14 -> rd=0, m_valid clears after the accept; resumes with 0x15 at col=1, row=1.
REQ-041 Reset mid-frame after 3 pixels -> rd=0 immediately and outputs idle; the next start's first pixel carries sof.
REQ-042 start pulsed during STREAM and during the done cycle -> ignored; exactly one frame and one done pulse.
